// File: rtl/vcx_issue_pkg.sv
// Shared types for the CX vector request issuer: request payload, writeback entry and FSM state.
package vcx_issue_pkg;

    localparam int VCX_DATA_WIDTH     = 32;
    localparam int VCX_INSTR_WIDTH    = 32;
    localparam int VCX_TRACK_ID_WIDTH = 4;

    typedef struct packed {
        logic [VCX_INSTR_WIDTH-1:0]    instr;
        logic [VCX_TRACK_ID_WIDTH-1:0] track_id;
        logic [VCX_DATA_WIDTH-1:0]     data0;
        logic [VCX_DATA_WIDTH-1:0]     data1;
        logic [2:0]                    vxrm;
    } vcx_req_t;

    typedef struct packed {
        logic [VCX_TRACK_ID_WIDTH-1:0] track_id;
        logic [VCX_DATA_WIDTH-1:0]     data;
    } vcx_wb_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        QUIESCED = 2'd2
    } vcx_issue_state_e;

endpackage

// File: rtl/vcx_req_issuer_if.sv
// Issue, request, response and writeback signals of the CX vector issuer.
// A transfer happens on a rising clk edge where valid and ready are both 1; valid never waits on ready, and the
// payload stays stable while valid & !ready. resp_valid has no ready: it is a one-cycle pulse that is always taken.
interface vcx_req_issuer_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int INSTR_WIDTH    = 32,
    parameter int TRACK_ID_WIDTH = 4
);
    logic                      issue_valid;
    logic                      issue_ready;
    logic [INSTR_WIDTH-1:0]    issue_instr;
    logic [TRACK_ID_WIDTH-1:0] issue_track_id;
    logic [DATA_WIDTH-1:0]     issue_rs1;
    logic [DATA_WIDTH-1:0]     issue_rs2;
    logic [2:0]                issue_vxrm;

    logic                      req_valid;
    logic                      req_ready;
    logic [INSTR_WIDTH-1:0]    req_instr;
    logic [TRACK_ID_WIDTH-1:0] req_track_id;
    logic [DATA_WIDTH-1:0]     req_data0;
    logic [DATA_WIDTH-1:0]     req_data1;
    logic [2:0]                req_vxrm;

    logic                      resp_valid;
    logic [DATA_WIDTH-1:0]     resp_data;

    logic                      wb_valid;
    logic                      wb_ready;
    logic [TRACK_ID_WIDTH-1:0] wb_track_id;
    logic [DATA_WIDTH-1:0]     wb_data;

    modport master (
        input  issue_valid, issue_instr, issue_track_id, issue_rs1, issue_rs2, issue_vxrm,
        output issue_ready,
        output req_valid, req_instr, req_track_id, req_data0, req_data1, req_vxrm,
        input  req_ready,
        input  resp_valid, resp_data,
        output wb_valid, wb_track_id, wb_data,
        input  wb_ready
    );

    modport slave (
        output issue_valid, issue_instr, issue_track_id, issue_rs1, issue_rs2, issue_vxrm,
        input  issue_ready,
        input  req_valid, req_instr, req_track_id, req_data0, req_data1, req_vxrm,
        output req_ready,
        output resp_valid, resp_data,
        input  wb_valid, wb_track_id, wb_data,
        output wb_ready
    );

endinterface

// File: rtl/vcx_sync_fifo.sv
// Synchronous FIFO with a flop-array store, read head taken straight from the array, and full/empty/count.
// DEPTH must be a power of two so the pointers wrap naturally.
module vcx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vcx_req_issuer.sv
// CX vector request issuer: registers core instructions onto req_*, pairs in-order responses with their tags and
// queues them for writeback under a credit limit. Define VCX_RESP_TIMEOUT_EN to build the response watchdog.
module vcx_req_issuer
    import vcx_issue_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int INSTR_WIDTH     = 32,
    parameter int TRACK_ID_WIDTH  = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    vcx_req_issuer_if.master        bus,
    input  logic                    quiesce,
    output logic                    idle,
    output logic                    err_spurious,
    output logic                    err_timeout,
    output vcx_issue_state_e        state_dbg
);
    localparam int CRW = $clog2(MAX_OUTSTANDING + 1);

    // The payload structs are sized by the package, so the module widths must agree with them.
    if ($bits(vcx_req_t) != INSTR_WIDTH + TRACK_ID_WIDTH + 2 * DATA_WIDTH + 3) begin : g_req_width_chk
        $error("vcx_req_issuer: widths disagree with vcx_issue_pkg");
    end
    if (MAX_OUTSTANDING < 2 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_depth_chk
        $error("vcx_req_issuer: MAX_OUTSTANDING must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_tout_chk
        $error("vcx_req_issuer: TIMEOUT_CYCLES must be >= 2");
    end

    vcx_issue_state_e          state_q, state_d;
    vcx_req_t                  req_q;
    logic                      req_valid_q;
    logic [CRW-1:0]            credits_q;
    logic                      issue_hs, req_hs, wb_hs;
    logic [TRACK_ID_WIDTH-1:0] tag_head;
    logic                      tag_empty, tag_full, tag_push, tag_pop;
    logic [CRW-1:0]            tag_count, wb_count;
    vcx_wb_t                   wb_din, wb_head;
    logic                      wb_push, wb_empty, wb_full;
    logic                      spurious;
    logic                      unused_fifo_status;

    assign issue_hs = bus.issue_valid && bus.issue_ready;
    assign req_hs   = req_valid_q && bus.req_ready;
    assign wb_hs    = bus.wb_valid && bus.wb_ready;

    assign bus.issue_ready = !rst && (state_q == RUN) && (credits_q < CRW'(MAX_OUTSTANDING))
                             && (!req_valid_q || bus.req_ready);

    assign bus.req_valid    = req_valid_q;
    assign bus.req_instr    = req_q.instr;
    assign bus.req_track_id = req_q.track_id;
    assign bus.req_data0    = req_q.data0;
    assign bus.req_data1    = req_q.data1;
    assign bus.req_vxrm     = req_q.vxrm;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid_q <= 1'b0;
            req_q       <= '0;
        end else if (issue_hs) begin
            req_valid_q    <= 1'b1;
            req_q.instr    <= bus.issue_instr;
            req_q.track_id <= bus.issue_track_id;
            req_q.data0    <= bus.issue_rs1;
            req_q.data1    <= bus.issue_rs2;
            req_q.vxrm     <= bus.issue_vxrm;
        end else if (req_hs) begin
            req_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credits_q <= '0;
        end else begin
            case ({issue_hs, wb_hs})
                2'b10:   credits_q <= credits_q + CRW'(1);
                2'b01:   credits_q <= credits_q - CRW'(1);
                default: credits_q <= credits_q;
            endcase
        end
    end

    // A response landing with an empty tag FIFO but a request going out this cycle is that request's
    // zero-latency answer: its tag goes straight to writeback instead of through the FIFO.
    assign tag_push = req_hs && !(bus.resp_valid && tag_empty);
    assign tag_pop  = bus.resp_valid && !tag_empty;
    assign wb_push  = bus.resp_valid && (!tag_empty || req_hs);
    assign spurious = bus.resp_valid && tag_empty && !req_hs;

    assign wb_din.track_id = tag_empty ? req_q.track_id : tag_head;
    assign wb_din.data     = bus.resp_data;

    vcx_sync_fifo #(.WIDTH(TRACK_ID_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tag_push),
        .push_data(req_q.track_id),
        .pop      (tag_pop),
        .pop_data (tag_head),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (tag_count)
    );

    vcx_sync_fifo #(.WIDTH($bits(vcx_wb_t)), .DEPTH(MAX_OUTSTANDING)) u_wb_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wb_push),
        .push_data(wb_din),
        .pop      (wb_hs),
        .pop_data (wb_head),
        .full     (wb_full),
        .empty    (wb_empty),
        .count    (wb_count)
    );

    assign unused_fifo_status = &{1'b0, tag_full, wb_full, tag_count, wb_count};

    assign bus.wb_valid    = !wb_empty;
    assign bus.wb_track_id = wb_head.track_id;
    assign bus.wb_data     = wb_head.data;

    always_ff @(posedge clk) begin
        if (rst) err_spurious <= 1'b0;
        else if (spurious) err_spurious <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:      if (quiesce) state_d = DRAIN;
            DRAIN:    if (!req_valid_q && credits_q == '0) state_d = QUIESCED;
            QUIESCED: if (!quiesce) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    assign state_dbg = state_q;
    assign idle      = (state_q == QUIESCED) || (!req_valid_q && credits_q == '0);

`ifdef VCX_RESP_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYCLES);

    logic [TOW-1:0] tout_cnt_q;
    logic           err_timeout_q;
    logic           tout_clear;

    assign tout_clear = bus.resp_valid || tag_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            tout_cnt_q    <= '0;
            err_timeout_q <= 1'b0;
        end else if (tout_clear) begin
            tout_cnt_q <= '0;
        end else if (tout_cnt_q == TOW'(TIMEOUT_CYCLES - 1)) begin
            err_timeout_q <= 1'b1;
        end else begin
            tout_cnt_q <= tout_cnt_q + TOW'(1);
        end
    end

    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_vcx_req_issuer.sv
// Self-checking bench for vcx_req_issuer: directed scenarios plus a scoreboard of expected {track_id, data}
// writebacks. The fake coprocessor echoes req_data0 back as the response payload.
module tb_vcx_req_issuer;
    import vcx_issue_pkg::*;

    localparam int DW   = 32;
    localparam int IW   = 32;
    localparam int TW   = 4;
    localparam int MAXO = 8;
`ifdef VCX_RESP_TIMEOUT_EN
    localparam logic TOUT_EXP = 1'b1;
`else
    localparam logic TOUT_EXP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             quiesce = 1'b0;
    logic             idle, err_spurious, err_timeout;
    vcx_issue_state_e state_dbg;

    vcx_req_issuer_if #(.DATA_WIDTH(DW), .INSTR_WIDTH(IW), .TRACK_ID_WIDTH(TW)) bus ();

    vcx_req_issuer #(
        .DATA_WIDTH(DW), .INSTR_WIDTH(IW), .TRACK_ID_WIDTH(TW),
        .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .quiesce     (quiesce),
        .idle        (idle),
        .err_spurious(err_spurious),
        .err_timeout (err_timeout),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the end of the run");
        $fatal(1, "time limit");
    end

    // scoreboard
    logic [TW+DW-1:0] exp_q[$];
    logic [DW-1:0]    cop_q[$];
    int tests_run    = 0;
    int tests_failed = 0;
    int req_hs_cnt   = 0;
    int wb_cnt       = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.req_valid && bus.req_ready) begin
            cop_q.push_back(bus.req_data0);
            req_hs_cnt++;
        end
        if (!rst && bus.wb_valid && bus.wb_ready) begin
            wb_cnt++;
            if (exp_q.size() == 0) check("wb_unexpected", exp_q.size(), 1);
            else check("wb_id_data", {bus.wb_track_id, bus.wb_data}, exp_q.pop_front());
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [TW-1:0] id, input logic [DW-1:0] rs1, input logic [IW-1:0] instr);
        bit done = 1'b0;
        bus.issue_valid    = 1'b1;
        bus.issue_track_id = id;
        bus.issue_rs1      = rs1;
        bus.issue_rs2      = ~rs1;
        bus.issue_instr    = instr;
        bus.issue_vxrm     = id[2:0];
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (bus.issue_ready) done = 1'b1;
        end
        if (done) begin
            @(posedge clk);
            #1;
            exp_q.push_back({id, rs1});
        end else begin
            check("issue_accept_timeout", done, 1);
        end
        bus.issue_valid = 1'b0;
    endtask

    task automatic send_resp();
        if (cop_q.size() == 0) begin
            check("resp_without_request", cop_q.size(), 1);
            return;
        end
        bus.resp_valid = 1'b1;
        bus.resp_data  = cop_q.pop_front();
        @(posedge clk);
        #1;
        bus.resp_valid = 1'b0;
    endtask

    initial begin
        int base;
        bus.issue_valid = 1'b1;
        bus.issue_instr = '0; bus.issue_track_id = '0; bus.issue_rs1 = '0; bus.issue_rs2 = '0; bus.issue_vxrm = '0;
        bus.req_ready = 1'b0; bus.resp_valid = 1'b0; bus.resp_data = '0; bus.wb_ready = 1'b0;

        // reset state
        step(3);
        check("rst_issue_ready", bus.issue_ready, 0);
        check("rst_req_valid", bus.req_valid, 0);
        check("rst_wb_valid", bus.wb_valid, 0);
        rst = 1'b0;
        bus.issue_valid = 1'b0;
        #1;
        check("rst_idle", idle, 1);
        check("rst_err_spurious", err_spurious, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_state", state_dbg, RUN);
        check("rst_issue_ready_after", bus.issue_ready, 1);

        // single request / response
        bus.req_ready = 1'b1;
        bus.wb_ready  = 1'b1;
        issue(4'd3, 32'd16, 32'h0000_7057);
        check("t1_req_valid", bus.req_valid, 1);
        check("t1_req_id", bus.req_track_id, 3);
        check("t1_req_instr", bus.req_instr, 32'h0000_7057);
        check("t1_req_data0", bus.req_data0, 16);
        step(5);
        send_resp();
        check("t1_wb_valid", bus.wb_valid, 1);
        check("t1_wb_id", bus.wb_track_id, 3);
        check("t1_wb_data", bus.wb_data, 16);
        step(2);
        check("t1_idle", idle, 1);

        // credit limit
        for (int i = 0; i < MAXO; i++) issue(TW'(i), $urandom, 32'h0000_0057 | (i << 12));
        bus.issue_valid    = 1'b1;
        bus.issue_track_id = 4'd8;
        step(2);
        @(negedge clk);
        check("t2_ninth_blocked", bus.issue_ready, 0);
        bus.issue_valid = 1'b0;
        step(1);
        send_resp();
        check("t2_blocked_until_wb", bus.issue_ready, 0);
        step(1);
        check("t2_credit_back", bus.issue_ready, 1);
        for (int i = 1; i < MAXO; i++) send_resp();
        step(3);
        check("t2_idle", idle, 1);

        // request held under back-pressure
        bus.req_ready = 1'b0;
        issue(4'd5, 32'hA5A5_0005, 32'h1234_5057);
        base = req_hs_cnt;
        for (int i = 0; i < 4; i++) begin
            check("t3_held_valid", bus.req_valid, 1);
            check("t3_held_id", bus.req_track_id, 5);
            check("t3_held_data0", bus.req_data0, 32'hA5A5_0005);
            check("t3_held_instr", bus.req_instr, 32'h1234_5057);
            check("t3_no_push", req_hs_cnt, base);
            step(1);
        end
        bus.req_ready = 1'b1;
        step(1);
        check("t3_one_push", req_hs_cnt, base + 1);
        check("t3_req_dropped", bus.req_valid, 0);
        send_resp();
        step(2);

        // writeback back-pressure and ordering
        bus.wb_ready = 1'b0;
        for (int i = 1; i <= 3; i++) issue(TW'(i), 32'h100 + i, 32'h0000_1057);
        step(1);
        for (int i = 0; i < 3; i++) send_resp();
        check("t4_wb_count", dut.u_wb_fifo.count, 3);
        check("t4_wb_head_id", bus.wb_track_id, 1);
        base = wb_cnt;
        bus.wb_ready = 1'b1;
        step(4);
        check("t4_wb_drained", wb_cnt - base, 3);

        // quiesce with outstanding requests
        issue(4'd6, 32'h66, 32'h0000_2057);
        issue(4'd7, 32'h77, 32'h0000_2057);
        step(1);
        quiesce = 1'b1;
        step(1);
        check("t5_issue_blocked", bus.issue_ready, 0);
        check("t5_not_idle", idle, 0);
        check("t5_state_drain", state_dbg, DRAIN);
        send_resp();
        send_resp();
        step(3);
        check("t5_idle", idle, 1);
        check("t5_state_quiesced", state_dbg, QUIESCED);
        quiesce = 1'b0;
        step(1);
        check("t5_state_run", state_dbg, RUN);
        check("t5_issue_ready", bus.issue_ready, 1);

        // zero-latency response: tag bypasses the FIFO
        bus.req_ready = 1'b0;
        issue(4'd10, 32'h0BAD_F00D, 32'h0000_3057);
        bus.req_ready  = 1'b1;
        bus.resp_valid = 1'b1;
        bus.resp_data  = 32'h0BAD_F00D;
        step(1);
        bus.resp_valid = 1'b0;
        void'(cop_q.pop_front());
        check("t6_wb_valid", bus.wb_valid, 1);
        check("t6_wb_id", bus.wb_track_id, 10);
        check("t6_wb_data", bus.wb_data, 32'h0BAD_F00D);
        check("t6_no_spurious", err_spurious, 0);
        step(2);

        // reset mid-operation: the late response is spurious
        issue(4'd4, 32'h44, 32'h0000_4057);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("t7_rst_idle", idle, 1);
        check("t7_rst_req_valid", bus.req_valid, 0);
        send_resp();
        check("t7_stale_spurious", err_spurious, 1);
        check("t7_stale_no_wb", bus.wb_valid, 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        #1;
        check("t7_err_cleared", err_spurious, 0);
        bus.resp_valid = 1'b1;
        bus.resp_data  = 32'hDEAD_BEEF;
        step(1);
        bus.resp_valid = 1'b0;
        check("t7_spurious", err_spurious, 1);
        step(2);
        check("t7_no_wb", bus.wb_valid, 0);
        check("t7_spurious_sticky", err_spurious, 1);

        // random traffic
        for (int i = 0; i < 6; i++) issue(TW'($urandom_range(0, 15)), $urandom, $urandom);
        for (int i = 0; i < 6; i++) begin
            send_resp();
            step($urandom_range(0, 2));
        end
        step(3);
        check("t8_sb_empty", exp_q.size(), 0);

        // response watchdog
        issue(4'd9, 32'h99, 32'h0000_5057);
        step(1100);
        check("t9_err_timeout", err_timeout, TOUT_EXP);
        send_resp();
        step(3);
        check("t9_idle", idle, 1);
        check("t9_sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
